// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory arbiter.
//               Provides the arbiter state encoding, the owner IDs that tag
//               the single outstanding read, and the latency-counter type.
// Ports       : none (package)
// Macros      : MEM_ARB_DATA_PRIORITY_EN (used by rr_arb2, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter state: IDLE accepts a new issue, WAIT covers an outstanding read
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    // Owner of the outstanding read
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Latency counter covers MEM_LAT-1 for MEM_LAT in 1..7
    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] lat_cnt_t;

    // Value loaded into the latency counter on a read issue
    function automatic lat_cnt_t lat_init(input int lat);
        return lat_cnt_t'(lat - 1);
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the core, the arbiter and the unified
//               memory. The "slave" modport is the arbiter's view; the
//               "master" modport is the view of the core plus the memory.
// Signals     : fetch port  if_req/if_addr -> if_gnt/if_rvalid/if_rdata
//               data port   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata
//               memory side mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata
//               core hold   stall
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // Memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    // Pipeline freeze
    logic          stall;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester grant logic (fetch vs data). Grants are
//               combinational; the last-grant flag is registered.
//               Default build: round-robin, the port not granted last wins a
//               tie, last_d resets to 1 so fetch wins the first tie.
//               With MEM_ARB_DATA_PRIORITY_EN defined: data always wins.
// Ports       : clk, reset (async, active-low)
//               en      - issue slot available
//               req_if  - fetch request      gnt_if - fetch grant
//               req_d   - data request       gnt_d  - data grant
// Macros      : MEM_ARB_DATA_PRIORITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire  clk,
    input  wire  reset,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

`ifdef MEM_ARB_DATA_PRIORITY_EN

    // Fixed priority needs no state; clock and reset are left unused
    logic w_unused;
    assign w_unused = clk ^ reset;

    assign gnt_d  = en & req_d;
    assign gnt_if = en & req_if & ~req_d;

`else

    logic r_last_d;
    logic w_pick_d;

    // Data wins when it is alone, or on a tie when fetch was granted last
    assign w_pick_d = req_d & (~req_if | ~r_last_d);

    assign gnt_d  = en & w_pick_d;
    assign gnt_if = en & req_if & ~w_pick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b1;
        end else if (gnt_if | gnt_d) begin
            r_last_d <= gnt_d;
        end
    end

`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port unified memory between the fetch port
//               and the load/store port. One transaction is issued at a time;
//               reads have fixed latency MEM_LAT (1..7) and only one read is
//               outstanding. Stores complete at issue. stall freezes the core
//               while any port waits or a read is in flight.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               bus   - mem_arbiter_if.slave (fetch, data, memory, stall)
// Parameters  : AW (address width), DW (data width), MEM_LAT (read latency)
// Macros      : MEM_ARB_DATA_PRIORITY_EN - data has fixed priority over
//               fetch (see rr_arb2); default is round-robin
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  wire          clk,
    input  wire          reset,
    mem_arbiter_if.slave bus
);

    arb_state_t r_state, w_state_nxt;
    lat_cnt_t   r_cnt,   w_cnt_nxt;
    logic       r_owner, w_owner_nxt;

    logic          w_issue_en;
    logic          w_gnt_if;
    logic          w_gnt_d;
    logic          w_read_issue;
    logic          w_rsp_done;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    logic          r_if_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic          r_d_rvalid;
    logic [DW-1:0] r_d_rdata;

    // Grants are suppressed while reset is held so the outputs read as zero
    assign w_issue_en = (r_state == ARB_IDLE) & reset;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (w_issue_en),
        .req_if (bus.if_req),
        .req_d  (bus.d_req),
        .gnt_if (w_gnt_if),
        .gnt_d  (w_gnt_d)
    );

    // A fetch is always a read; a data grant is a read only for loads
    assign w_read_issue = w_gnt_if | (w_gnt_d & ~bus.d_we);

    // Last WAIT cycle: mem_rdata is valid and is captured at this edge
    assign w_rsp_done = (r_state == ARB_WAIT) && (r_cnt == '0);

    // ---------------------------------------------------------------- datapath
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt_d) begin
            w_mem_addr  = bus.d_addr;
            w_mem_wdata = bus.d_wdata;
        end else if (w_gnt_if) begin
            w_mem_addr  = bus.if_addr;
        end
    end

    assign bus.mem_en    = w_gnt_if | w_gnt_d;
    assign bus.mem_we    = w_gnt_d & bus.d_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.if_gnt    = w_gnt_if;
    assign bus.d_gnt     = w_gnt_d;

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_IF;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (w_read_issue) begin
                    w_state_nxt = ARB_WAIT;
                    w_cnt_nxt   = lat_init(MEM_LAT);
                    w_owner_nxt = w_gnt_d ? OWN_D : OWN_IF;
                end
            end
            ARB_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - lat_cnt_t'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // --------------------------------------------------------- read response
    // rvalid pulses the cycle after capture; rdata holds until the next
    // response to the same port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (w_rsp_done) begin
                if (r_owner == OWN_D) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= bus.mem_rdata;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;

    // ------------------------------------------------------------------- stall
    assign bus.stall = reset & ((bus.if_req & ~w_gnt_if) |
                                (bus.d_req  & ~w_gnt_d)  |
                                (r_state == ARB_WAIT));

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port and the load/store data port of the MIPS core.
- Accepts one transaction at a time and tracks fixed-latency reads.
- Arbitrates contention round-robin and raises stall so the core freezes its PC and pipeline registers while a port waits.
- Sits between the core (the pc/instr and aluout/writedata/readdata buses) and a merged imem/dmem array.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, cycles from issue to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch read request, held until if_gnt
- if_addr  input  AW  fetch byte address
- if_gnt  output  1  fetch request issued this cycle
- if_rvalid  output  1  one-cycle pulse: if_rdata valid
- if_rdata  output  DW  fetched instruction, held until next fetch response
- d_req  input  1  data request, held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data byte address
- d_wdata  input  DW  store data
- d_gnt  output  1  data request issued this cycle
- d_rvalid  output  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  output  DW  load data, held until next load response
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory byte address (memory uses [AW-1:2])
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after issue
- stall  output  1  core must hold state

Behaviour:
- States: IDLE and WAIT. At most one read is outstanding.
- IDLE, no request: outputs quiet, mem_en=0.
- IDLE, a request present:
  - Pick the winner; gnt is combinational in the same cycle.
  - mem_en=1, and mem_addr/mem_we/mem_wdata are muxed from the winner.
  - Fetch always issues mem_we=0.
- Store (d_we=1) completes at issue: no rvalid, state stays IDLE, next issue possible the following cycle.
- Read issued in cycle T:
  - Latency counter loads MEM_LAT-1; state goes to WAIT, holding the owner ID.
  - mem_rdata is sampled at the end of cycle T+MEM_LAT into the owner's rdata register.
  - Owner's rvalid=1 in cycle T+MEM_LAT+1; state is back in IDLE that cycle, so a new issue is allowed.
  - Read-to-read throughput is 1 per MEM_LAT+1 cycles.
- WAIT: no grants, mem_en=0, requests stay pending.
- Round-robin:
  - Flag last_d = 1 if the previous grant went to data.
  - On contention, grant the port not granted last. With a single requester, grant it regardless.
  - last_d updates on every grant.
  - Reset value last_d=1, so fetch wins the first tie.
- Requests are level, must stay stable until gnt, and may drop after gnt.
  - A req dropped before gnt is simply not serviced.
- stall = (if_req & ~if_gnt) | (d_req & ~d_gnt) | (state==WAIT).
- Simultaneous rvalid and new issue in the same cycle is legal. rvalid goes to the old owner; gnt goes to the new winner.
- Address is passed unchanged; misaligned addresses are not checked.
- Reset (asynchronous, reset=0):
  - State=IDLE, counter=0, last_d=1.
  - All gnt/rvalid/mem_en/mem_we=0, rdata registers=0, stall=0.
  - Reset during WAIT abandons the read; no rvalid is produced after release.

Optional Feature:
- MEM_ARB_DATA_PRIORITY_EN defined: fixed priority; data always wins contention, and last_d is unused (tied off).
- Not defined: round-robin as specified above.

Decomposition:
- Package mem_arb_pkg:
  - State encoding (ARB_IDLE, ARB_WAIT).
  - Owner ID constants (OWN_IF=0, OWN_D=1).
  - Latency counter width constant (3 bits).
- One sub-module, rr_arb2:
  - Two-requester grant logic with the last-grant flag, clk and reset.
  - Compiles to fixed priority under the macro.
- Latency counter, owner register and datapath muxing stay in mem_arbiter.

Test Plan:
- Reset release, if_req=1, if_addr=0x0, mem returns 0x20020005, MEM_LAT=1 -> if_gnt in cycle 0, if_rvalid in cycle 2 with if_rdata=0x20020005, stall=1 in cycle 1 only.
- if_req and d_req (load 0x54) both high from reset -> fetch granted first, data granted in the next IDLE cycle, then fetch again. Grants alternate IF,D,IF,D over 4 reads.
- Store d_addr=0x0, d_wdata=7 with if_req high -> d_gnt with mem_we=1, mem_wdata=7, no d_rvalid; fetch granted the next cycle.
- MEM_LAT=3, back-to-back fetches -> grants 4 cycles apart, each if_rvalid exactly 4 cycles after its gnt, stall high in every non-grant cycle.
- reset asserted in WAIT of a load -> all outputs 0 immediately; after release no stale d_rvalid, and the next request is served normally.
- MEM_ARB_DATA_PRIORITY_EN defined, continuous contention -> d_gnt on every issue slot, if_gnt only when d_req=0.
